// File: rtl/cpc_mem_mapper.sv
// CPC memory mapper and SRAM controller: gate-array RAM banking, upper-ROM paging
// into SRAM, and a boot-load handshake that fills the ROM area before normal operation.
module cpc_mem_mapper #(
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned EXP_BLOCKS = 7,
  parameter int unsigned ROM_SLOTS  = 16,
  parameter int unsigned ROM_BASE   = 32'h0010_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 boot_restart,
  input  logic [15:0]          cpu_addr,
  input  logic                 iorq_n,
  input  logic                 wr_n,
  input  logic [7:0]           cpu_dout,
  input  logic                 cpu_n,
  input  logic                 romen_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 mwe_n,
  input  logic [15:0]          vram_addr,
  input  logic [ROM_SLOTS-1:0] rom_slot_mask,
  input  logic                 boot_req,
  input  logic [ADDR_W-1:0]    boot_addr,
  input  logic [7:0]           boot_data,
  input  logic                 boot_end,
  output logic                 boot_ack,
  output logic                 rom_ready,
  output logic                 ext_rom_sel,
  output logic [7:0]           ram_dout,
  output logic [5:0]           ram_cfg,
  output logic [ADDR_W-1:0]    sram_addr,
  input  logic [7:0]           sram_din,
  output logic [7:0]           sram_dout,
  output logic                 sram_we_n,
  output logic                 sram_oe_n
);

  typedef enum logic [1:0] {B_IDLE, B_WR, B_ACK, B_RUN} boot_state_e;

  // NOTE: the boot FSM is deliberately outside reset_n so a warm reset keeps the loaded
  // ROM image usable; it powers up in B_IDLE and only boot_restart sends it back there.
  boot_state_e state = B_IDLE;
  boot_state_e state_d;

  always_ff @(posedge clk) begin
    state <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      B_IDLE: begin
        if (boot_end)      state_d = B_RUN;
        else if (boot_req) state_d = B_WR;
      end
      B_WR:    state_d = B_ACK;
      B_ACK:   if (!boot_req) state_d = B_IDLE;
      B_RUN:   state_d = B_RUN;
      default: state_d = B_IDLE;
    endcase
    if (boot_restart) state_d = B_IDLE;
  end

  logic run;
  logic boot_wr_start;
  assign run           = (state == B_RUN);
  assign boot_wr_start = (state == B_IDLE) && (state_d == B_WR);
  assign rom_ready     = run;

  // Gate-array RAM config (7Fxx, function bits 11) and upper-ROM select (DFxx).
  logic       io_wr;
  logic       ga_cfg_wr;
  logic       rom_sel_wr;
  logic       blk_present;
  logic [5:0] cfg_wr_val;
  logic [7:0] rom_bank;

  assign io_wr       = !iorq_n && !wr_n;
  assign ga_cfg_wr   = io_wr && (cpu_addr[15:14] == 2'b01) && (cpu_dout[7:6] == 2'b11);
  assign rom_sel_wr  = io_wr && !cpu_addr[13];
  assign blk_present = 32'(cpu_dout[5:3]) < EXP_BLOCKS;
  assign cfg_wr_val  = {cpu_dout[5:3], blk_present ? cpu_dout[2:0] : 3'b000};

  // NOTE: sequential state uses non-blocking assignments only; reset has priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_cfg  <= '0;
      rom_bank <= '0;
    end else begin
      if (ga_cfg_wr)  ram_cfg  <= cfg_wr_val;
      if (rom_sel_wr) rom_bank <= cpu_dout;
    end
  end

  // Upper ROM is served from SRAM only for populated slots in range.
  logic [255:0] mask_ext;
  logic         bank_in_range;
  assign mask_ext      = 256'(rom_slot_mask);
  assign bank_in_range = 32'(rom_bank) < ROM_SLOTS;
  assign ext_rom_sel   = !cpu_n && !romen_n && (cpu_addr[15:14] == 2'b11)
                         && bank_in_range && mask_ext[rom_bank];

  // 6128 page table: each 16KB CPU page goes to a base page Bn or expansion page Xn.
  logic [1:0]  page;
  logic [1:0]  page_idx;
  logic        page_exp;
  logic [31:0] ram_addr32;
  logic [31:0] rom_addr32;
  logic [ADDR_W-1:0] mapped_addr;

  assign page = cpu_addr[15:14];

  always_comb begin
    page_exp = 1'b0;
    page_idx = page;
    case (ram_cfg[2:0])
      3'd1: if (page == 2'd3) page_exp = 1'b1;
      3'd2: page_exp = 1'b1;
      3'd3: begin
        if (page == 2'd1) page_idx = 2'd3;
        if (page == 2'd3) page_exp = 1'b1;
      end
      3'd4, 3'd5, 3'd6, 3'd7: begin
        if (page == 2'd1) begin
          page_exp = 1'b1;
          page_idx = ram_cfg[1:0];
        end
      end
      default: ;
    endcase
  end

  assign ram_addr32 = (page_exp ? ((32'(ram_cfg[5:3]) + 32'd1) << 16) : 32'd0)
                      + {16'd0, page_idx, cpu_addr[13:0]};
  assign rom_addr32 = 32'(ROM_BASE) + (32'(rom_bank) << 14) + 32'(cpu_addr[13:0]);

  always_comb begin
    if (cpu_n)            mapped_addr = ADDR_W'(vram_addr);
    else if (ext_rom_sel) mapped_addr = ADDR_W'(rom_addr32);
    else                  mapped_addr = ADDR_W'(ram_addr32);
  end

  // NOTE: the address register is pure datapath and is not reset; every use of it is
  // preceded by a RAS or boot load, so a reset term would only add fan-out.
  logic [ADDR_W-1:0] addr_q;
  always_ff @(posedge clk) begin
    if (boot_wr_start)      addr_q <= boot_addr;
    else if (run && !ras_n) addr_q <= mapped_addr;
  end

  assign sram_addr = addr_q;
  assign sram_dout = run ? cpu_dout : boot_data;

  // Strobes are registered; a boot write is a single-cycle low pulse in B_WR.
  logic we_n_d;
  logic oe_n_d;
  always_comb begin
    we_n_d = 1'b1;
    if (state_d == B_WR) we_n_d = 1'b0;
    else if (run)        we_n_d = ras_n | cas_n | mwe_n;
    oe_n_d = run ? !we_n_d : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      boot_ack  <= 1'b0;
      ram_dout  <= '0;
    end else begin
      sram_we_n <= we_n_d;
      sram_oe_n <= oe_n_d;
      boot_ack  <= (state_d == B_ACK);
      if (run && ((!ras_n && !cas_n && mwe_n) || ext_rom_sel)) ram_dout <= sram_din;
    end
  end

endmodule

// File: tb/tb_cpc_mem_mapper.sv
// Self-checking bench for cpc_mem_mapper: a page-table model predicts mapping, config,
// ROM paging and strobes every cycle; directed vectors pin boot handshake and corner cases.
module tb_cpc_mem_mapper;
  localparam int ADDR_W = 21;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        boot_restart = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        iorq_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_n = 1'b0;
  logic        romen_n = 1'b1;
  logic        ras_n = 1'b1;
  logic        cas_n = 1'b1;
  logic        mwe_n = 1'b1;
  logic [15:0] vram_addr = '0;
  logic [15:0] rom_slot_mask = 16'h0021;
  logic        boot_req = 1'b0;
  logic [ADDR_W-1:0] boot_addr = '0;
  logic [7:0]  boot_data = '0;
  logic        boot_end = 1'b0;
  logic [7:0]  sram_din = '0;

  logic        boot_ack, rom_ready, ext_rom_sel, sram_we_n, sram_oe_n;
  logic [7:0]  ram_dout, sram_dout;
  logic [5:0]  ram_cfg;
  logic [ADDR_W-1:0] sram_addr;

  logic        boot_ack0, rom_ready0, ext_rom_sel0, sram_we_n0, sram_oe_n0;
  logic [7:0]  ram_dout0, sram_dout0;
  logic [5:0]  ram_cfg0;
  logic [ADDR_W-1:0] sram_addr0;

  cpc_mem_mapper dut (
    .clk(clk), .reset_n(reset_n), .boot_restart(boot_restart), .cpu_addr(cpu_addr),
    .iorq_n(iorq_n), .wr_n(wr_n), .cpu_dout(cpu_dout), .cpu_n(cpu_n), .romen_n(romen_n),
    .ras_n(ras_n), .cas_n(cas_n), .mwe_n(mwe_n), .vram_addr(vram_addr),
    .rom_slot_mask(rom_slot_mask), .boot_req(boot_req), .boot_addr(boot_addr),
    .boot_data(boot_data), .boot_end(boot_end), .boot_ack(boot_ack), .rom_ready(rom_ready),
    .ext_rom_sel(ext_rom_sel), .ram_dout(ram_dout), .ram_cfg(ram_cfg), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  cpc_mem_mapper #(.EXP_BLOCKS(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .boot_restart(boot_restart), .cpu_addr(cpu_addr),
    .iorq_n(iorq_n), .wr_n(wr_n), .cpu_dout(cpu_dout), .cpu_n(cpu_n), .romen_n(romen_n),
    .ras_n(ras_n), .cas_n(cas_n), .mwe_n(mwe_n), .vram_addr(vram_addr),
    .rom_slot_mask(rom_slot_mask), .boot_req(boot_req), .boot_addr(boot_addr),
    .boot_data(boot_data), .boot_end(boot_end), .boot_ack(boot_ack0), .rom_ready(rom_ready0),
    .ext_rom_sel(ext_rom_sel0), .ram_dout(ram_dout0), .ram_cfg(ram_cfg0), .sram_addr(sram_addr0),
    .sram_din(sram_din), .sram_dout(sram_dout0), .sram_we_n(sram_we_n0), .sram_oe_n(sram_oe_n0)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: CPC 6128 page table, codes 0-3 = base page Bn, 4-7 = expansion page X(n-4).
  int page_tbl [8][4] = '{'{0,1,2,3}, '{0,1,2,7}, '{4,5,6,7}, '{0,3,2,7},
                          '{0,4,2,3}, '{0,5,2,3}, '{0,6,2,3}, '{0,7,2,3}};

  function automatic bit model_ext(logic cn, logic [15:0] a, logic rn, int bank, logic [15:0] mask);
    if (cn || rn || a < 16'hC000 || bank >= 16) return 1'b0;
    return mask[bank];
  endfunction

  function automatic int model_addr(logic cn, logic [15:0] a, logic [15:0] va, logic rn,
                                    int cfg, int bank, logic [15:0] mask);
    int pg, off, code;
    if (cn) return int'(va);
    off = a % 'h4000;
    if (model_ext(cn, a, rn, bank, mask)) return 'h100000 + bank * 'h4000 + off;
    pg   = a / 'h4000;
    code = page_tbl[cfg % 8][pg];
    if (code < 4) return code * 'h4000 + off;
    return (cfg / 8 + 1) * 'h10000 + (code - 4) * 'h4000 + off;
  endfunction

  logic exp_ready  = 1'b0;
  logic chk_en     = 1'b0;
  int   m_cfg      = 0;
  int   m_bank     = 0;
  int   m_dout     = 0;
  int   exp_addr   = 0;
  bit   addr_valid = 0;
  bit   we_valid   = 0;
  bit   m_we       = 1;
  bit   m_oe       = 1;
  int   we_cnt     = 0;

  always @(posedge clk) begin
    if (exp_ready && !ras_n) begin
      exp_addr   = model_addr(cpu_n, cpu_addr, vram_addr, romen_n, m_cfg, m_bank, rom_slot_mask);
      addr_valid = 1;
    end else if (!exp_ready && boot_req) begin
      addr_valid = 0;
    end
    if (!reset_n) begin
      m_we = 1; m_oe = 1; we_valid = 1; m_dout = 0;
    end else if (exp_ready) begin
      m_we = ras_n | cas_n | mwe_n;
      m_oe = !m_we;
      we_valid = 1;
      if ((!ras_n && !cas_n && mwe_n) || model_ext(cpu_n, cpu_addr, romen_n, m_bank, rom_slot_mask))
        m_dout = int'(sram_din);
    end else begin
      we_valid = 0;
    end
    if (!reset_n) begin
      m_cfg = 0; m_bank = 0;
    end else if (!iorq_n && !wr_n) begin
      if (cpu_addr[15:14] == 2'b01 && cpu_dout[7:6] == 2'b11)
        m_cfg = (int'(cpu_dout[5:3]) >= 7) ? int'(cpu_dout[5:3]) * 8 : int'(cpu_dout[5:0]);
      if (!cpu_addr[13]) m_bank = int'(cpu_dout);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp ram_cfg", ram_cfg, m_cfg);
      check("cmp rom_ready", rom_ready, exp_ready);
      check("cmp ext_rom_sel", ext_rom_sel,
            model_ext(cpu_n, cpu_addr, romen_n, m_bank, rom_slot_mask));
      check("cmp ram_dout", ram_dout, m_dout);
      if (addr_valid) check("cmp sram_addr", sram_addr, exp_addr);
      if (we_valid) begin
        check("cmp sram_we_n", sram_we_n, m_we);
        check("cmp sram_oe_n", sram_oe_n, m_oe);
      end
      if (exp_ready) check("cmp boot_ack idle in RUN", boot_ack, 0);
      if (!sram_we_n) we_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic boot_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    boot_addr = a; boot_data = d; boot_req = 1'b1;
    cyc();
    check("boot wr we_n low", sram_we_n, 0);
    check("boot wr addr", sram_addr, a);
    check("boot wr data", sram_dout, d);
    check("boot wr ack low", boot_ack, 0);
    cyc();
    check("boot ack we_n high", sram_we_n, 1);
    check("boot ack high", boot_ack, 1);
    cyc();
    check("boot ack held", boot_ack, 1);
    boot_req = 1'b0;
    cyc();
    check("boot ack released", boot_ack, 0);
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; iorq_n = 1'b0; wr_n = 1'b0;
    cyc();
    iorq_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic mem_rd(input string nm, input logic cn, input logic [15:0] a,
                        input logic [15:0] va, input logic rn, input logic cas,
                        input logic [7:0] din, input logic [31:0] ea, input logic ee,
                        input logic [7:0] ed);
    cpu_n = cn; cpu_addr = a; vram_addr = va; romen_n = rn;
    ras_n = 1'b0; cas_n = cas; mwe_n = 1'b1; sram_din = din;
    cyc();
    check({nm, " sram_addr"}, sram_addr, ea);
    check({nm, " ext_rom_sel"}, ext_rom_sel, ee);
    check({nm, " ram_dout"}, ram_dout, ed);
    ras_n = 1'b1; cas_n = 1'b1; romen_n = 1'b1; cpu_n = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(); cyc();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    check("reset ram_cfg", ram_cfg, 0);
    check("reset ram_dout", ram_dout, 0);
    check("reset we_n", sram_we_n, 1);
    check("reset oe_n", sram_oe_n, 1);
    check("reset boot_ack", boot_ack, 0);
    check("reset rom_ready", rom_ready, 0);

    boot_write(21'h100000, 8'hA5);
    boot_write(21'h100001, 8'h5A);
    boot_write(21'h100002, 8'h3C);
    boot_end = 1'b1;
    cyc();
    boot_end = 1'b0; exp_ready = 1'b1;
    check("boot rom_ready", rom_ready, 1);
    check("boot we pulses", we_cnt, 3);

    io_write(16'h7F00, 8'hC1);
    check("cfg C1", ram_cfg, 6'h01);
    check("exp0 cfg C1", ram_cfg0, 6'h00);
    mem_rd("cfg1 rd C000", 1'b0, 16'hC000, 16'h0000, 1'b1, 1'b0, 8'h11, 32'h01C000, 1'b0, 8'h11);
    check("exp0 rd C000", sram_addr0, 32'h00C000);

    io_write(16'hDF00, 8'h05);
    mem_rd("rom5 C123", 1'b0, 16'hC123, 16'h0000, 1'b0, 1'b1, 8'h22, 32'h114123, 1'b1, 8'h22);
    io_write(16'hFF00, 8'h00);
    mem_rd("rom FF00 ignored", 1'b0, 16'hC123, 16'h0000, 1'b0, 1'b1, 8'h23, 32'h114123, 1'b1, 8'h23);
    rom_slot_mask = 16'h0001;
    mem_rd("rom5 unpop", 1'b0, 16'hC123, 16'h0000, 1'b0, 1'b1, 8'h33, 32'h01C123, 1'b0, 8'h23);
    io_write(16'hDF00, 8'd20);
    rom_slot_mask = 16'hFFFF;
    mem_rd("rom20 out of range", 1'b0, 16'hC123, 16'h0000, 1'b0, 1'b1, 8'h44, 32'h01C123, 1'b0, 8'h23);
    rom_slot_mask = 16'h0021;

    io_write(16'h7F00, 8'h85);
    check("cfg palette ignored", ram_cfg, 6'h01);
    io_write(16'h7F00, 8'hFE);
    check("cfg FE absent block", ram_cfg, 6'h38);
    mem_rd("video 4000", 1'b1, 16'h8000, 16'h4000, 1'b1, 1'b0, 8'h55, 32'h004000, 1'b0, 8'h55);
    mem_rd("cfgFE rd 4000", 1'b0, 16'h4000, 16'h0000, 1'b1, 1'b0, 8'h66, 32'h004000, 1'b0, 8'h66);
    io_write(16'h7F00, 8'hF6);
    check("cfg F6", ram_cfg, 6'h36);
    mem_rd("cfgF6 rd 4000", 1'b0, 16'h4000, 16'h0000, 1'b1, 1'b0, 8'h67, 32'h078000, 1'b0, 8'h67);
    mem_rd("cfgF6 video", 1'b1, 16'h4000, 16'h4000, 1'b1, 1'b0, 8'h68, 32'h004000, 1'b0, 8'h68);
    io_write(16'h7F00, 8'hC2);
    mem_rd("cfg2 rd 0000", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 8'h69, 32'h010000, 1'b0, 8'h69);
    mem_rd("cfg2 rd 8000", 1'b0, 16'h8000, 16'h0000, 1'b1, 1'b0, 8'h6A, 32'h018000, 1'b0, 8'h6A);
    io_write(16'h7F00, 8'hC3);
    mem_rd("cfg3 rd 4000", 1'b0, 16'h4000, 16'h0000, 1'b1, 1'b0, 8'h6B, 32'h00C000, 1'b0, 8'h6B);

    cpu_addr = 16'h4000; cpu_dout = 8'h9C; ras_n = 1'b0; cas_n = 1'b0; mwe_n = 1'b0;
    cyc();
    check("ram wr we_n", sram_we_n, 0);
    check("ram wr oe_n", sram_oe_n, 1);
    check("ram wr data", sram_dout, 8'h9C);
    check("ram wr addr", sram_addr, 32'h00C000);
    ras_n = 1'b1; cas_n = 1'b1; mwe_n = 1'b1;
    cyc();
    check("ram wr end we_n", sram_we_n, 1);
    check("ram wr end oe_n", sram_oe_n, 0);

    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    check("warm reset ram_cfg", ram_cfg, 0);
    check("warm reset rom_ready", rom_ready, 1);
    check("warm reset ram_dout", ram_dout, 0);
    mem_rd("rom bank0 after reset", 1'b0, 16'hC000, 16'h0000, 1'b0, 1'b1, 8'h77, 32'h100000, 1'b1, 8'h77);

    boot_restart = 1'b1;
    cyc();
    boot_restart = 1'b0; exp_ready = 1'b0;
    check("restart rom_ready", rom_ready, 0);
    cpu_addr = 16'h0000; ras_n = 1'b0; cas_n = 1'b0; mwe_n = 1'b0;
    cyc();
    check("idle no ram write", sram_we_n, 1);
    mwe_n = 1'b1; sram_din = 8'h88;
    cyc();
    check("idle ram_dout hold", ram_dout, 8'h77);
    check("idle addr hold", sram_addr, 32'h100000);
    ras_n = 1'b1; cas_n = 1'b1;

    boot_req = 1'b1; boot_end = 1'b1;
    cyc();
    boot_end = 1'b0; exp_ready = 1'b1;
    check("req+end rom_ready", rom_ready, 1);
    check("req+end no write", sram_we_n, 1);
    check("req+end ack", boot_ack, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("run req ignored", boot_ack, 0);
    end
    boot_req = 1'b0;
    cyc();
    check("total we pulses", we_cnt, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
